mult_ctrl: RTL and testbench

Sequencing controller for the 16x9 shift-add sequential multiplier. It drives the operand register block's `LOAD_MX`/`LOAD_MY`/`SFT_MY` strobes and the product accumulator's clear/add/shift strobes. It runs exactly `MY_WIDTH` add/shift iterations per multiply and reports completion with a one-cycle `DONE` pulse. It sits between the top-level start/done handshake and the datapath, and holds no operand data itself.

---
 rtl/mult_ctrl.sv | 101 ++++++++++
 tb/tb_mult_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mult_ctrl.sv
// Sequencing controller for the 16x9 shift-add multiplier.
// Drives the operand/accumulator strobes and the start/done handshake.
module mult_ctrl #(
   parameter int MY_WIDTH = 9,
   parameter int CNT_W    = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic             i_my_bit,
   output logic             o_load_mx,
   output logic             o_load_my,
   output logic             o_sft_my,
   output logic             o_clr_acc,
   output logic             o_add_en,
   output logic             o_sft_acc,
   output logic             o_busy,
   output logic             o_done,
   output logic [CNT_W-1:0] o_iter
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_ADD   = 3'd2,
      S_SHIFT = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(MY_WIDTH);

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_iter;
   logic [CNT_W-1:0] w_iter_inc;

   assign w_iter_inc = r_iter + CNT_W'(1);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_iter  <= '0;
      end else begin
         r_state <= w_next;
         if (w_next == S_LOAD) begin
            r_iter <= '0;
         end else if (r_state == S_SHIFT) begin
            r_iter <= w_iter_inc;
         end
      end
   end

   always_comb begin
      w_next = S_IDLE;
      case (r_state)
         S_IDLE:  w_next = i_start ? S_LOAD : S_IDLE;
         S_LOAD:  w_next = S_ADD;
         S_ADD:   w_next = S_SHIFT;
         S_SHIFT: w_next = (w_iter_inc == LP_LAST) ? S_DONE : S_ADD;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // ADD_EN is the only output with a path from an input
   always_comb begin
      o_load_mx = 1'b0;
      o_load_my = 1'b0;
      o_sft_my  = 1'b0;
      o_clr_acc = 1'b0;
      o_add_en  = 1'b0;
      o_sft_acc = 1'b0;
      o_busy    = 1'b0;
      o_done    = 1'b0;
      case (r_state)
         S_LOAD: begin
            o_load_mx = 1'b1;
            o_load_my = 1'b1;
            o_clr_acc = 1'b1;
            o_busy    = 1'b1;
         end
         S_ADD: begin
            o_add_en = i_my_bit;
            o_busy   = 1'b1;
         end
         S_SHIFT: begin
            o_sft_my  = 1'b1;
            o_sft_acc = 1'b1;
            o_busy    = 1'b1;
         end
         S_DONE: begin
            o_done = 1'b1;
            o_busy = 1'b1;
         end
         default: ;
      endcase
   end

   assign o_iter = r_iter;

endmodule

// File: tb/tb_mult_ctrl.sv
// Bench for mult_ctrl: datapath model plus directed
// per-cycle vector tables and multi-cycle corner sequences.
module tb_mult_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       my_bit;
   logic       load_mx, load_my, sft_my, clr_acc;
   logic       add_en, sft_acc, busy, done;
   logic [3:0] iter;

   logic [15:0] mx_in = '0;
   logic [8:0]  my_in = '0;
   logic [15:0] mx_r = '0;
   logic [8:0]  my_r = '0;
   logic [25:0] acc = '0;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic        rst;
      logic        start;
      logic [7:0]  exp_str;
      logic [3:0]  exp_iter;
   } vec_t;

   vec_t vecs[22];

   always #5 clk = ~clk;

   mult_ctrl dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_start   (start),
      .i_my_bit  (my_bit),
      .o_load_mx (load_mx),
      .o_load_my (load_my),
      .o_sft_my  (sft_my),
      .o_clr_acc (clr_acc),
      .o_add_en  (add_en),
      .o_sft_acc (sft_acc),
      .o_busy    (busy),
      .o_done    (done),
      .o_iter    (iter)
   );

   // operand register block and 25-bit accumulator (+carry)
   always @(posedge clk) begin
      if (load_mx) mx_r <= mx_in;
      if (load_my) my_r <= my_in;
      else if (sft_my) my_r <= my_r >> 1;
      if (clr_acc) acc <= '0;
      else if (add_en) acc <= acc + {1'b0, mx_r, 9'b0};
      else if (sft_acc) acc <= acc >> 1;
   end

   assign my_bit = my_r[0];

   function automatic logic [7:0] strobes();
      return {load_mx, load_my, sft_my, clr_acc,
              add_en, sft_acc, busy, done};
   endfunction

   task automatic check(string name, logic [31:0] act,
                        logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // one multiply starting in cycle 0, timing taken from the spec
   task automatic fill(logic [8:0] m, logic [3:0] it0, bit extra);
      for (int c = 0; c < 22; c++) begin
         vecs[c].rst   = 1'b0;
         vecs[c].start = (c == 0) || (extra && (c == 5 || c == 19));
         if (c == 0) begin
            vecs[c].exp_str  = 8'b0000_0000;
            vecs[c].exp_iter = it0;
         end else if (c == 1) begin
            vecs[c].exp_str  = 8'b1101_0010;
            vecs[c].exp_iter = 4'd0;
         end else if (c <= 19 && (c % 2) == 0) begin
            vecs[c].exp_str  = {4'b0000, m[(c-2)/2], 3'b010};
            vecs[c].exp_iter = 4'((c - 2) / 2);
         end else if (c <= 19) begin
            vecs[c].exp_str  = 8'b0010_0110;
            vecs[c].exp_iter = 4'((c - 3) / 2);
         end else if (c == 20) begin
            vecs[c].exp_str  = 8'b0000_0011;
            vecs[c].exp_iter = 4'd9;
         end else begin
            vecs[c].exp_str  = 8'b0000_0000;
            vecs[c].exp_iter = 4'd9;
         end
      end
   endtask

   task automatic run_table(string name, logic [24:0] prod);
      for (int c = 0; c < 22; c++) begin
         rst   = vecs[c].rst;
         start = vecs[c].start;
         @(negedge clk);
         check($sformatf("%s c%0d", name, c),
               {20'd0, strobes(), iter},
               {20'd0, vecs[c].exp_str, vecs[c].exp_iter});
         if (c == 20)
            check({name, " product"}, {6'd0, acc}, {7'd0, prod});
         next_cycle();
      end
      start = 1'b0;
   endtask

   initial begin
      bit seen;
      rst = 1'b1;
      start = 1'b0;
      next_cycle();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("reset outs", {20'd0, strobes(), iter}, 32'd0);
         next_cycle();
      end
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check("idle outs", {20'd0, strobes(), iter}, 32'd0);
         next_cycle();
      end

      mx_in = 16'd3;
      my_in = 9'd5;
      fill(9'd5, 4'd0, 1'b0);
      run_table("mul3x5", 25'd15);

      mx_in = 16'hFFFF;
      my_in = 9'h1FF;
      fill(9'h1FF, 4'd9, 1'b0);
      run_table("mulmax", 25'h1FEFE01);

      mx_in = 16'd3;
      my_in = 9'd5;
      fill(9'd5, 4'd9, 1'b1);
      run_table("ignstart", 25'd15);

      // reset in the middle of an operation
      for (int c = 0; c < 12; c++) begin
         start = (c == 0);
         rst   = (c == 10);
         if (c == 11) begin
            @(negedge clk);
            check("midrst idle", {20'd0, strobes(), iter}, 32'd0);
         end
         next_cycle();
      end
      rst = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         if (done || busy) seen = 1'b1;
         next_cycle();
      end
      check("midrst no done", {31'd0, seen}, 32'd0);

      // START held high: back-to-back multiplies
      start = 1'b1;
      for (int c = 0; c < 46; c++) begin
         @(negedge clk);
         check($sformatf("b2b c%0d", c),
               {29'd0, load_mx, done, busy},
               {29'd0, c >= 1 && (c - 1) % 21 == 0,
                c % 21 == 20, c >= 1 && c % 21 != 0});
         next_cycle();
      end
      start = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
